// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared constants and types for the RV32I/RV64I instruction-decode stage.
//   - Major opcodes (INST_*), func3 encodings, funct7 encodings.
//   - id_bundle_t: the control part of the decoded bundle.
//   - is_shift(): func3 test shared by OP-IMM and OP decoding.
// No ports; imported by id_decode and id_stage.
// ---------------------------------------------------------------------------
package id_pkg;

  // Major opcodes
  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;  // OP-IMM
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;  // OP (and M extension)
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;  // BRANCH
  localparam logic [6:0] INST_TYPE_L   = 7'b0000011;  // LOAD
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;  // STORE
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;

  // func3: OP-IMM / OP
  localparam logic [2:0] INST_ADD_SUB  = 3'b000;
  localparam logic [2:0] INST_SLL      = 3'b001;
  localparam logic [2:0] INST_SRL_SRA  = 3'b101;

  // func3: BRANCH
  localparam logic [2:0] INST_BEQ  = 3'b000;
  localparam logic [2:0] INST_BNE  = 3'b001;
  localparam logic [2:0] INST_BLT  = 3'b100;
  localparam logic [2:0] INST_BGE  = 3'b101;
  localparam logic [2:0] INST_BLTU = 3'b110;
  localparam logic [2:0] INST_BGEU = 3'b111;

  // func3: LOAD
  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LD  = 3'b011;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_LWU = 3'b110;

  // func3: STORE
  localparam logic [2:0] INST_SB = 3'b000;
  localparam logic [2:0] INST_SH = 3'b001;
  localparam logic [2:0] INST_SW = 3'b010;
  localparam logic [2:0] INST_SD = 3'b011;

  // funct7
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;  // SUB / SRA
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;  // RV32M

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       reg_wen;
    logic       mem_rd_req;
    logic       mem_wr_req;
    logic       illegal;
  } id_bundle_t;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == INST_SLL) || (f3 == INST_SRL_SRA);
  endfunction

endpackage

// File: rtl/id_decode.sv
// ---------------------------------------------------------------------------
// id_decode
// Purely combinational instruction -> operand/control bundle decoder.
// Optional feature: define ID_STAGE_MEXT_EN to decode OP with funct7=0000001
// (RV32M) as a legal register-register instruction; otherwise it is illegal.
// Ports:
//   inst, inst_addr          instruction word and its PC
//   rs1_data, rs2_data       register-file read data
//   rs1_addr, rs2_addr       read addresses (0 for an unused source)
//   op_num1, op_num2         ALU operands
//   base_addr, addr_offset   branch/jump/memory address terms
//   ctrl                     rd, reg_wen, memory requests, illegal flag
// ---------------------------------------------------------------------------
module id_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] op_num1,
  output logic [XLEN-1:0] op_num2,
  output logic [XLEN-1:0] base_addr,
  output logic [XLEN-1:0] addr_offset,
  output id_bundle_t      ctrl
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Immediates are built as signed 32-bit values; the size cast sign-extends
  // them to XLEN.
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i32 = {{20{inst[31]}}, inst[31:20]};
  assign imm_s32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u32 = {inst[31:12], 12'b0};

  assign imm_i = XLEN'(imm_i32);
  assign imm_s = XLEN'(imm_s32);
  assign imm_b = XLEN'(imm_b32);
  assign imm_j = XLEN'(imm_j32);
  assign imm_u = XLEN'(imm_u32);

  logic [XLEN-1:0] shamt_imm, shamt_reg, const_four;
  assign shamt_imm  = {{(XLEN-SHW){1'b0}}, inst[20 +: SHW]};
  assign shamt_reg  = {{(XLEN-SHW){1'b0}}, rs2_data[SHW-1:0]};
  assign const_four = XLEN'(4);

  logic rs1_use, rs2_use, rd_wr, mem_rd, mem_wr, illegal;

  always_comb begin
    rs1_use     = 1'b0;
    rs2_use     = 1'b0;
    rd_wr       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    illegal     = 1'b0;
    op_num1     = '0;
    op_num2     = '0;
    base_addr   = '0;
    addr_offset = '0;

    case (opcode)
      INST_TYPE_I: begin
        rs1_use = 1'b1;
        rd_wr   = 1'b1;
        op_num1 = rs1_data;
        op_num2 = is_shift(funct3) ? shamt_imm : imm_i;
      end

      INST_TYPE_R_M: begin
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        rd_wr   = 1'b1;
        op_num1 = rs1_data;
        if (funct7 == FUNCT7_MEXT) begin
`ifdef ID_STAGE_MEXT_EN
          op_num2 = rs2_data;
`else
          illegal = 1'b1;
`endif
        end else if ((funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_ALT) &&
                      ((funct3 == INST_ADD_SUB) || (funct3 == INST_SRL_SRA)))) begin
          op_num2 = is_shift(funct3) ? shamt_reg : rs2_data;
        end else begin
          illegal = 1'b1;
        end
      end

      INST_TYPE_B: begin
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        op_num1     = rs1_data;
        op_num2     = rs2_data;
        base_addr   = inst_addr;
        addr_offset = imm_b;
        case (funct3)
          INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end

      INST_TYPE_L: begin
        rs1_use     = 1'b1;
        rd_wr       = 1'b1;
        mem_rd      = 1'b1;
        base_addr   = rs1_data;
        addr_offset = imm_i;
        case (funct3)
          INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: illegal = 1'b0;
          INST_LD, INST_LWU: illegal = (XLEN != 64);
          default: illegal = 1'b1;
        endcase
      end

      INST_TYPE_S: begin
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        mem_wr      = 1'b1;
        op_num2     = rs2_data;
        base_addr   = rs1_data;
        addr_offset = imm_s;
        case (funct3)
          INST_SB, INST_SH, INST_SW: illegal = 1'b0;
          INST_SD: illegal = (XLEN != 64);
          default: illegal = 1'b1;
        endcase
      end

      INST_JAL: begin
        rd_wr       = 1'b1;
        op_num1     = inst_addr;
        op_num2     = const_four;
        base_addr   = inst_addr;
        addr_offset = imm_j;
      end

      INST_JALR: begin
        rs1_use     = 1'b1;
        rd_wr       = 1'b1;
        op_num1     = inst_addr;
        op_num2     = const_four;
        base_addr   = rs1_data;
        addr_offset = imm_i;
        illegal     = (funct3 != 3'b000);
      end

      INST_LUI: begin
        rd_wr   = 1'b1;
        op_num1 = imm_u;
      end

      INST_AUIPC: begin
        rd_wr   = 1'b1;
        op_num1 = inst_addr;
        op_num2 = imm_u;
      end

      default: illegal = 1'b1;
    endcase
  end

  // Unused sources read x0 so they can never match a pending load target.
  assign rs1_addr = rs1_use ? inst[19:15] : 5'd0;
  assign rs2_addr = rs2_use ? inst[24:20] : 5'd0;

  // Illegal instructions still travel downstream but must not write state.
  always_comb begin
    ctrl.illegal    = illegal;
    ctrl.rd_addr    = (rd_wr && !illegal) ? rd : 5'd0;
    ctrl.reg_wen    = rd_wr && !illegal && (rd != 5'd0);
    ctrl.mem_rd_req = mem_rd && !illegal;
    ctrl.mem_wr_req = mem_wr && !illegal;
  end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Registered RV32I/RV64I decode stage between IF and EX. Decodes one
// instruction per cycle (id_decode), holds the bundle in an output register
// and inserts load-use interlock stalls.
// Optional feature: ID_STAGE_MEXT_EN (RV32M decode, handled in id_decode).
// Parameters: XLEN (32/64), LOAD_LAT (0..7 cycles of load-use hold).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid_i / in_ready_o        IF-side handshake
//   inst_i, inst_addr_i            instruction and PC from IF
//   rs1_addr_o, rs2_addr_o         register-file read addresses (comb)
//   rs1_data_i, rs2_data_i         register-file read data (same cycle)
//   flush_i                        kill held bundle, refuse input
//   out_valid_o / out_ready_i      EX-side handshake
//   inst_o, inst_addr_o, op_num1_o, op_num2_o, rd_addr_o, reg_wen_o,
//   base_addr_o, addr_offset_o, mem_rd_req_o, mem_wr_req_o, illegal_o
//                                  registered decoded bundle
// ---------------------------------------------------------------------------
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op_num1_o,
  output logic [XLEN-1:0] op_num2_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o,
  output logic [XLEN-1:0] base_addr_o,
  output logic [XLEN-1:0] addr_offset_o,
  output logic            mem_rd_req_o,
  output logic            mem_wr_req_o,
  output logic            illegal_o
);

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  logic [XLEN-1:0] dec_op1, dec_op2, dec_base, dec_off;
  id_bundle_t      dec_ctrl;

  id_decode #(.XLEN(XLEN)) u_decode (
    .inst        (inst_i),
    .inst_addr   (inst_addr_i),
    .rs1_data    (rs1_data_i),
    .rs2_data    (rs2_data_i),
    .rs1_addr    (rs1_addr_o),
    .rs2_addr    (rs2_addr_o),
    .op_num1     (dec_op1),
    .op_num2     (dec_op2),
    .base_addr   (dec_base),
    .addr_offset (dec_off),
    .ctrl        (dec_ctrl)
  );

  // Handshake: a transfer happens on a side only in a cycle where both its
  // valid and ready are high. out_valid_o never depends on out_ready_i and
  // the bundle stays frozen while out_valid_o=1 and out_ready_i=0. Input is
  // accepted when the output register is free or draining this cycle, no
  // load-use hazard is pending and no flush is requested.
  logic       in_fire, out_fire, hazard;
  logic [2:0] cnt;
  logic [4:0] ld_rd;

  // ld_rd is never x0, and unused sources decode to x0, so no extra
  // "source used" qualification is needed here.
  assign hazard     = (LOAD_LAT != 0) && (cnt != 3'd0) &&
                      ((rs1_addr_o == ld_rd) || (rs2_addr_o == ld_rd));
  assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o   <= 1'b0;
      inst_o        <= '0;
      inst_addr_o   <= '0;
      op_num1_o     <= '0;
      op_num2_o     <= '0;
      rd_addr_o     <= '0;
      reg_wen_o     <= 1'b0;
      base_addr_o   <= '0;
      addr_offset_o <= '0;
      mem_rd_req_o  <= 1'b0;
      mem_wr_req_o  <= 1'b0;
      illegal_o     <= 1'b0;
      cnt           <= '0;
      ld_rd         <= '0;
    end else begin
      // flush_i forces in_ready_o low, so it can never coincide with in_fire.
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (in_fire) begin
        out_valid_o   <= 1'b1;
        inst_o        <= inst_i;
        inst_addr_o   <= inst_addr_i;
        op_num1_o     <= dec_op1;
        op_num2_o     <= dec_op2;
        rd_addr_o     <= dec_ctrl.rd_addr;
        reg_wen_o     <= dec_ctrl.reg_wen;
        base_addr_o   <= dec_base;
        addr_offset_o <= dec_off;
        mem_rd_req_o  <= dec_ctrl.mem_rd_req;
        mem_wr_req_o  <= dec_ctrl.mem_wr_req;
        illegal_o     <= dec_ctrl.illegal;
      end else if (out_fire) begin
        out_valid_o <= 1'b0;
      end

      // The counter only starts once the load actually leaves this stage;
      // flush leaves it alone because that load is older than the flush.
      if (out_fire && mem_rd_req_o && (rd_addr_o != 5'd0) && (LOAD_LAT != 0)) begin
        cnt   <= LAT;
        ld_rd <= rd_addr_o;
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam int XLEN     = 32;
  localparam int LOAD_LAT = 2;

  localparam logic [31:0] I_ADDI  = 32'hFFD08293; // addi x5, x1, -3
  localparam logic [31:0] I_LW    = 32'h00012303; // lw   x6, 0(x2)
  localparam logic [31:0] I_ADDD  = 32'h001303B3; // add  x7, x6, x1
  localparam logic [31:0] I_ADDI2 = 32'h002083B3; // add  x7, x1, x2
  localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2, 8(x1)
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1, x2, +8
  localparam logic [31:0] I_BBAD  = 32'h0020A463; // branch, func3=010
  localparam logic [31:0] I_JAL   = 32'hFF9FF0EF; // jal  x1, -8
  localparam logic [31:0] I_LUI   = 32'h12345537; // lui  x10, 0x12345
  localparam logic [31:0] I_BADOP = 32'h0000037F; // opcode 0x7F, rd=6
  localparam logic [31:0] I_MUL   = 32'h022081B3; // mul  x3, x1, x2

  logic            clk;
  logic            rst_n;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [4:0]      rs1_addr_o, rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o, op_num1_o, op_num2_o, base_addr_o, addr_offset_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o, mem_rd_req_o, mem_wr_req_o, illegal_o;

  int n_cmp = 0;
  int n_err = 0;

  id_stage #(.XLEN(XLEN), .LOAD_LAT(LOAD_LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .flush_i       (flush_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .op_num1_o     (op_num1_o),
    .op_num2_o     (op_num2_o),
    .rd_addr_o     (rd_addr_o),
    .reg_wen_o     (reg_wen_o),
    .base_addr_o   (base_addr_o),
    .addr_offset_o (addr_offset_o),
    .mem_rd_req_o  (mem_rd_req_o),
    .mem_wr_req_o  (mem_wr_req_o),
    .illegal_o     (illegal_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary, required finish before 200000");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    inst_i      = 32'h00000013;
    inst_addr_i = '0;
    rs1_data_i  = '0;
    rs2_data_i  = '0;
  endtask

  // Present one instruction for one accepted cycle; caller checks the result.
  task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    inst_i      = ins;
    inst_addr_i = pc;
    rs1_data_i  = d1;
    rs2_data_i  = d2;
    in_valid_i  = 1'b1;
    step();
    in_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    n_cmp++;
    if ({inst_o, op_num1_o, op_num2_o, base_addr_o, addr_offset_o} !== '0) begin
      n_err++; $display("FAIL reset_data: inst %h op1 %h op2 %h expected all 0", inst_o, op_num1_o, op_num2_o);
    end
    n_cmp++;
    if ({rd_addr_o, reg_wen_o, mem_rd_req_o, mem_wr_req_o, illegal_o} !== 9'd0) begin
      n_err++; $display("FAIL reset_ctrl: got rd %0d wen %b rd_req %b wr_req %b ill %b expected 0",
                        rd_addr_o, reg_wen_o, mem_rd_req_o, mem_wr_req_o, illegal_o);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_addi();
    inst_i = I_ADDI; inst_addr_i = 32'h100; rs1_data_i = 32'd10; rs2_data_i = 32'h55;
    #1;
    n_cmp++;
    if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd0) begin
      n_err++; $display("FAIL addi_rs_addr: got %0d/%0d expected 1/0", rs1_addr_o, rs2_addr_o);
    end
    issue(I_ADDI, 32'h100, 32'd10, 32'h55);
    n_cmp++;
    if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b expected 1", out_valid_o); end
    n_cmp++;
    if (op_num1_o !== 32'd10 || op_num2_o !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL addi_ops: got %h/%h expected 0000000a/fffffffd", op_num1_o, op_num2_o);
    end
    n_cmp++;
    if (rd_addr_o !== 5'd5 || reg_wen_o !== 1'b1 || inst_o !== I_ADDI || inst_addr_o !== 32'h100) begin
      n_err++; $display("FAIL addi_ctrl: got rd %0d wen %b inst %h pc %h expected 5 1 %h 100",
                        rd_addr_o, reg_wen_o, inst_o, inst_addr_o, I_ADDI);
    end
  endtask

  task automatic test_decode_misc();
    issue(I_SW, 32'h0, 32'h1000, 32'hCAFE);
    n_cmp++;
    if (mem_wr_req_o !== 1'b1 || reg_wen_o !== 1'b0 || mem_rd_req_o !== 1'b0) begin
      n_err++; $display("FAIL sw_ctrl: got wr %b wen %b rd %b expected 1 0 0", mem_wr_req_o, reg_wen_o, mem_rd_req_o);
    end
    n_cmp++;
    if (op_num2_o !== 32'hCAFE || base_addr_o !== 32'h1000 || addr_offset_o !== 32'd8) begin
      n_err++; $display("FAIL sw_addr: got op2 %h base %h off %h expected cafe 1000 8", op_num2_o, base_addr_o, addr_offset_o);
    end

    issue(I_BEQ, 32'h300, 32'h11, 32'h22);
    n_cmp++;
    if (op_num1_o !== 32'h11 || op_num2_o !== 32'h22 || base_addr_o !== 32'h300 ||
        addr_offset_o !== 32'd8 || reg_wen_o !== 1'b0) begin
      n_err++; $display("FAIL beq: got op1 %h op2 %h base %h off %h wen %b expected 11 22 300 8 0",
                        op_num1_o, op_num2_o, base_addr_o, addr_offset_o, reg_wen_o);
    end

    inst_i = I_JAL;
    #1;
    n_cmp++;
    if (rs1_addr_o !== 5'd0 || rs2_addr_o !== 5'd0) begin
      n_err++; $display("FAIL jal_rs_addr: got %0d/%0d expected 0/0", rs1_addr_o, rs2_addr_o);
    end
    issue(I_JAL, 32'h200, 32'h77, 32'h88);
    n_cmp++;
    if (op_num1_o !== 32'h200 || op_num2_o !== 32'd4 || base_addr_o !== 32'h200 ||
        addr_offset_o !== 32'hFFFFFFF8 || rd_addr_o !== 5'd1 || reg_wen_o !== 1'b1) begin
      n_err++; $display("FAIL jal: got op1 %h op2 %h base %h off %h rd %0d wen %b expected 200 4 200 fffffff8 1 1",
                        op_num1_o, op_num2_o, base_addr_o, addr_offset_o, rd_addr_o, reg_wen_o);
    end

    issue(I_LUI, 32'h40, 32'h5, 32'h6);
    n_cmp++;
    if (op_num1_o !== 32'h12345000 || op_num2_o !== 32'd0 || rd_addr_o !== 5'd10 || reg_wen_o !== 1'b1) begin
      n_err++; $display("FAIL lui: got op1 %h op2 %h rd %0d wen %b expected 12345000 0 10 1",
                        op_num1_o, op_num2_o, rd_addr_o, reg_wen_o);
    end
    step();
  endtask

  task automatic test_load_use();
    int stalls;
    issue(I_LW, 32'h400, 32'h100, 32'h0);
    n_cmp++;
    if (out_valid_o !== 1'b1 || mem_rd_req_o !== 1'b1 || rd_addr_o !== 5'd6 || reg_wen_o !== 1'b1 ||
        base_addr_o !== 32'h100 || addr_offset_o !== 32'd0) begin
      n_err++; $display("FAIL lw_bundle: got v %b rd_req %b rd %0d wen %b base %h off %h expected 1 1 6 1 100 0",
                        out_valid_o, mem_rd_req_o, rd_addr_o, reg_wen_o, base_addr_o, addr_offset_o);
    end
    step(); // lw leaves the stage here
    inst_i = I_ADDD; inst_addr_i = 32'h404; rs1_data_i = 32'h42; rs2_data_i = 32'h3;
    in_valid_i = 1'b1;
    #1;
    stalls = 0;
    for (int k = 0; k < 8 && in_ready_o !== 1'b1; k++) begin
      stalls++;
      step();
    end
    n_cmp++;
    if (stalls != 2) begin n_err++; $display("FAIL load_use_stalls: got %0d expected 2", stalls); end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 1'b1 || inst_o !== I_ADDD || op_num1_o !== 32'h42) begin
      n_err++; $display("FAIL load_use_accept: got v %b inst %h op1 %h expected 1 %h 42", out_valid_o, inst_o, op_num1_o, I_ADDD);
    end
    step();
  endtask

  task automatic test_independent();
    issue(I_LW, 32'h500, 32'h100, 32'h0);
    step(); // lw leaves, counter armed for x6
    inst_i = I_ADDI2; inst_addr_i = 32'h504; rs1_data_i = 32'h9; rs2_data_i = 32'h4;
    in_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL independent_ready: got %b expected 1", in_ready_o); end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (inst_o !== I_ADDI2 || op_num2_o !== 32'h4) begin
      n_err++; $display("FAIL independent_accept: got inst %h op2 %h expected %h 4", inst_o, op_num2_o, I_ADDI2);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    issue(I_ADDI, 32'h600, 32'd10, 32'h0);
    out_ready_i = 1'b0;
    inst_i = I_ADDI2; inst_addr_i = 32'h604; rs1_data_i = 32'd99; rs2_data_i = 32'd1;
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, in_ready_o); end
      step();
      n_cmp++;
      if (out_valid_o !== 1'b1 || inst_o !== I_ADDI || op_num1_o !== 32'd10 || inst_addr_o !== 32'h600) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v %b inst %h op1 %h pc %h expected 1 %h a 600",
                          k, out_valid_o, inst_o, op_num1_o, inst_addr_o, I_ADDI);
      end
    end
    out_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready_o); end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 1'b1 || inst_o !== I_ADDI2 || op_num1_o !== 32'd99) begin
      n_err++; $display("FAIL bp_release_load: got v %b inst %h op1 %h expected 1 %h 63", out_valid_o, inst_o, op_num1_o, I_ADDI2);
    end
    step();
  endtask

  task automatic test_flush();
    issue(I_ADDI, 32'h700, 32'd10, 32'h0);
    out_ready_i = 1'b0;
    inst_i = I_LW; inst_addr_i = 32'h704; rs1_data_i = 32'h100;
    in_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b expected 0", in_ready_o); end
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", out_valid_o); end
    n_cmp++;
    if (mem_rd_req_o !== 1'b0 || inst_o !== I_ADDI || inst_addr_o !== 32'h700) begin
      n_err++; $display("FAIL flush_hold: got rd_req %b inst %h pc %h expected 0 %h 700", mem_rd_req_o, inst_o, inst_addr_o, I_ADDI);
    end
    out_ready_i = 1'b1;
    step();
  endtask

  task automatic test_illegal();
    issue(I_BADOP, 32'h800, 32'h1, 32'h2);
    n_cmp++;
    if (out_valid_o !== 1'b1 || illegal_o !== 1'b1) begin
      n_err++; $display("FAIL badop_flag: got v %b ill %b expected 1 1", out_valid_o, illegal_o);
    end
    n_cmp++;
    if (reg_wen_o !== 1'b0 || mem_rd_req_o !== 1'b0 || mem_wr_req_o !== 1'b0) begin
      n_err++; $display("FAIL badop_ctrl: got wen %b rd %b wr %b expected 0 0 0", reg_wen_o, mem_rd_req_o, mem_wr_req_o);
    end
    issue(I_BBAD, 32'h804, 32'h1, 32'h2);
    n_cmp++;
    if (illegal_o !== 1'b1 || out_valid_o !== 1'b1) begin
      n_err++; $display("FAIL bad_func3: got ill %b v %b expected 1 1", illegal_o, out_valid_o);
    end
    step();
  endtask

  task automatic test_mext();
    logic exp_ill, exp_wen;
`ifdef ID_STAGE_MEXT_EN
    exp_ill = 1'b0; exp_wen = 1'b1;
`else
    exp_ill = 1'b1; exp_wen = 1'b0;
`endif
    issue(I_MUL, 32'h900, 32'd6, 32'd7);
    n_cmp++;
    if (illegal_o !== exp_ill || reg_wen_o !== exp_wen || out_valid_o !== 1'b1) begin
      n_err++; $display("FAIL mul: got ill %b wen %b v %b expected %b %b 1", illegal_o, reg_wen_o, out_valid_o, exp_ill, exp_wen);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    issue(I_LW, 32'hA00, 32'h100, 32'h0);
    step();
    inst_i = I_ADDD; rs1_data_i = 32'h5;
    in_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_before_reset: got %b expected 0", in_ready_o); end
    rst_n = 1'b0;
    in_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_clears_stall: got ready %b v %b expected 1 0", in_ready_o, out_valid_o);
    end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (inst_o !== I_ADDD || out_valid_o !== 1'b1) begin
      n_err++; $display("FAIL after_reset_accept: got inst %h v %b expected %h 1", inst_o, out_valid_o, I_ADDD);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    step();
    test_decode_misc();
    test_load_use();
    test_independent();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_mext();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
